// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide controller.
// MDU_MADD_EN enables the madd/maddu/msub/msubu opcodes (7..10).
package mdu_pkg;

  localparam int CNT_W = 4;

  localparam logic [3:0] MD_NONE  = 4'd0;
  localparam logic [3:0] MD_MULT  = 4'd1;
  localparam logic [3:0] MD_MULTU = 4'd2;
  localparam logic [3:0] MD_DIV   = 4'd3;
  localparam logic [3:0] MD_DIVU  = 4'd4;
  localparam logic [3:0] MD_MTHI  = 4'd5;
  localparam logic [3:0] MD_MTLO  = 4'd6;
  localparam logic [3:0] MD_MADD  = 4'd7;
  localparam logic [3:0] MD_MADDU = 4'd8;
  localparam logic [3:0] MD_MSUB  = 4'd9;
  localparam logic [3:0] MD_MSUBU = 4'd10;

  typedef enum logic {IDLE, RUN} mdu_state_e;

  // Ops that open a busy window.
  function automatic logic md_is_start(input logic [3:0] op);
    logic r;
    r = (op >= MD_MULT) && (op <= MD_DIVU);
`ifdef MDU_MADD_EN
    r = r || ((op >= MD_MADD) && (op <= MD_MSUBU));
`endif
    return r;
  endfunction

  function automatic logic md_is_div(input logic [3:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/mdu_calc.sv
// Combinational datapath: products, quotient/remainder and (with
// MDU_MADD_EN) accumulate against the current {HI,LO}.
module mdu_calc
  import mdu_pkg::*;
(
  input  logic [3:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
`ifdef MDU_MADD_EN
  input  logic [63:0] hilo_i,
`endif
  output logic [63:0] res_o,
  output logic        dz_o
);

  logic signed [63:0] sprod;
  logic        [63:0] uprod;
  logic               sdiv;
  logic        [31:0] dvd, dvs, dvs_safe, q_mag, r_mag, q, r;

  assign sprod = $signed({{32{a_i[31]}}, a_i}) * $signed({{32{b_i[31]}}, b_i});
  assign uprod = {32'd0, a_i} * {32'd0, b_i};

  // Signed divide runs on magnitudes, then fixes signs: quotient truncates
  // toward zero, remainder follows the dividend. 0x80000000/-1 wraps to
  // 0x80000000 naturally through the magnitude path.
  assign sdiv     = (op_i == MD_DIV);
  assign dvd      = (sdiv && a_i[31]) ? -a_i : a_i;
  assign dvs      = (sdiv && b_i[31]) ? -b_i : b_i;
  assign dvs_safe = (dvs == 32'd0) ? 32'd1 : dvs;
  assign q_mag    = dvd / dvs_safe;
  assign r_mag    = dvd % dvs_safe;
  assign q        = (sdiv && (a_i[31] ^ b_i[31])) ? -q_mag : q_mag;
  assign r        = (sdiv && a_i[31]) ? -r_mag : r_mag;

  assign dz_o = md_is_div(op_i) && (b_i == 32'd0);

  // Result select by opcode.
  always_comb begin
    res_o = 64'd0;
    case (op_i)
      MD_MULT:  res_o = sprod;
      MD_MULTU: res_o = uprod;
      MD_DIV,
      MD_DIVU:  res_o = {r, q};
`ifdef MDU_MADD_EN
      MD_MADD:  res_o = hilo_i + sprod;
      MD_MADDU: res_o = hilo_i + uprod;
      MD_MSUB:  res_o = hilo_i - sprod;
      MD_MSUBU: res_o = hilo_i - uprod;
`endif
      default:  res_o = 64'd0;
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// Multiply/divide controller: fixed-latency busy window, HI/LO ownership
// and D-stage stall request. MDU_MADD_EN adds madd/maddu/msub/msubu.
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [3:0]  E_MDOp,
  input  logic [31:0] E_A,
  input  logic [31:0] E_B,
  input  logic        D_IsMD,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic        Start,
  output logic        Busy,
  output logic        MDStall
);

  mdu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [63:0]      pend_q, pend_d;
  logic             dz_q, dz_d;
  logic [31:0]      hi_q, hi_d, lo_q, lo_d;
  logic [63:0]      calc_res;
  logic             calc_dz;

  mdu_calc u_calc (
    .op_i   (E_MDOp),
    .a_i    (E_A),
    .b_i    (E_B),
`ifdef MDU_MADD_EN
    .hilo_i ({hi_q, lo_q}),
`endif
    .res_o  (calc_res),
    .dz_o   (calc_dz)
  );

  assign Start   = (state_q == IDLE) && md_is_start(E_MDOp);
  assign Busy    = (state_q == RUN);
  assign MDStall = D_IsMD & (Start | Busy);
  assign HI      = hi_q;
  assign LO      = lo_q;

  // Next-state: launch latches the result, RUN counts down and commits on 1.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    dz_d    = dz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      IDLE: begin
        if (Start) begin
          state_d = RUN;
          cnt_d   = md_is_div(E_MDOp) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
          pend_d  = calc_res;
          dz_d    = calc_dz;
        end else if (E_MDOp == MD_MTHI) begin
          hi_d = E_A;
        end else if (E_MDOp == MD_MTLO) begin
          lo_d = E_A;
        end
      end
      RUN: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = IDLE;
          // Divide-by-zero keeps HI/LO as they were.
          if (!dz_q) {hi_d, lo_d} = pend_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and register file flops; reset discards any pending result.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pend_q  <= '0;
      dz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      dz_q    <= dz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
- Multiply/divide unit controller for the 5-stage pipeline: accepts mult/div/mthi/mtlo from the E stage and sequences a fixed-latency busy window.
- Owns the HI/LO registers that feed the E-stage ALU-B select path.
- Produces the D-stage stall request for MD-class instructions while an operation is pending.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (range 1..15)
- DIV_CYCLES, 10, busy cycles for div/divu (range 1..15)

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous, active-low reset
- E_MDOp  input  4  E-stage op: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo
- E_A  input  32  forwarded rs operand (post-bypass)
- E_B  input  32  forwarded rt operand (post-bypass)
- D_IsMD  input  1  D-stage instruction is mult/multu/div/divu/mfhi/mflo/mthi/mtlo
- HI  output  32  HI register
- LO  output  32  LO register
- Start  output  1  combinational; 1 when E_MDOp is 1..4 and the controller is IDLE
- Busy  output  1  registered; 1 while an operation is in flight
- MDStall  output  1  combinational; D_IsMD & (Start | Busy)

Behaviour:
- Reset (async, reset_n=0): HI=0, LO=0, Busy=0, counter=0, pending HI/LO=0, state=IDLE. Start and MDStall follow their equations with Busy=0.
- States:
  - IDLE: Busy=0.
  - RUN: Busy=1.
- IDLE→RUN on a clock edge with Start=1:
  - pending result computed from E_A/E_B and latched at that edge.
  - counter loads MULT_CYCLES (ops 1,2) or DIV_CYCLES (ops 3,4).
- RUN: counter decrements each edge. On the edge where counter==1: HI/LO load the pending result and state→IDLE.
- Timing: op in E in cycle t → Busy=1 in cycles t+1..t+N → new HI/LO visible from cycle t+N+1.
- Arithmetic:
  - mult: signed 64-bit product. multu: unsigned 64-bit product. HI=[63:32], LO=[31:0].
  - div/divu: LO=quotient, HI=remainder. Signed uses truncation toward zero; remainder takes the sign of the dividend.
  - div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
  - Divisor 0 (div or divu): the busy window still runs the full DIV_CYCLES; HI/LO are left unchanged at completion.
- mthi/mtlo (ops 5,6): when IDLE, HI or LO is written with E_A at the edge ending the cycle; no busy window.
- Any op with E_MDOp != 0 while Busy=1 is ignored. This cannot occur because MDStall holds it in D; the bench treats it as an assertion failure.
- mfhi/mflo reads use HI/LO combinationally through the E-stage mux; no bypass of the pending result.
- Ops 7..15: ignored, unless the optional feature below is compiled in.
- Reset mid-operation: pending result is discarded, Busy drops immediately, HI/LO return to 0.

Optional Feature:
MDU_MADD_EN
- Defined: adds op 7 madd, 8 maddu, 9 msub, 10 msubu.
  - Each uses MULT_CYCLES.
  - Result = {HI,LO} ± product, computed modulo 2^64 at Start time from the HI/LO values then current.
  - madd/msub use a signed product; maddu/msubu use an unsigned product.
- Undefined: ops 7..10 are ignored like the other unused encodings (no Start, no state change).

Decomposition:
- Package mdu_pkg:
  - op encoding constants (MD_NONE..MD_MSUBU)
  - state enum (IDLE, RUN)
  - counter width constant CNT_W=4
- Sub-module mdu_calc: purely combinational. Takes op, a, b, and current {HI,LO}. Returns 64-bit result plus a div-by-zero flag. mdu_ctrl holds all sequencing and registers.

Test Plan:
- mult A=0xFFFFFFFD B=5 at cycle t → Busy=1 for t+1..t+5; at t+6 HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- divu A=7 B=2 → Busy for 10 cycles, then LO=3, HI=1. div A=0xFFFFFFF9 (−7) B=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- mult in E with D_IsMD=1 → MDStall=1 in cycle t and through t+5; MDStall=0 at t+6. With D_IsMD=0 → MDStall=0 throughout.
- mthi A=0x12345678 → HI=0x12345678 next cycle, Busy stays 0, LO unchanged. div B=0 → after 10 busy cycles HI/LO unchanged.
- Reset: assert reset_n=0 at t+3 of a div → Busy=0, HI=0, LO=0 immediately. After release, a new mult completes normally.
- MDU_MADD_EN: HI=0, LO=0xFFFFFFFF, then maddu A=1 B=1 → after 5 cycles HI=1, LO=0.
